event_scheduler: RTL and testbench

Sequences all inputs that can move the active brick into the playfield state machine, one event at a time. It latches one-cycle key pulses and internally generated gravity ticks as pending requests, then arbitrates them by fixed priority. It presents exactly one event on a one-hot bus and holds it until the consumer acknowledges it. Gravity period is derived from the current level. The block sits between the PS/2 key decoder and the game FSM.

---
 rtl/event_scheduler_pkg.sv | 41 ++++
 rtl/event_scheduler_gravity_timer.sv | 80 ++++++++
 rtl/event_scheduler.sv | 115 +++++++++++
 tb/tb_event_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_scheduler_pkg.sv
// Shared definitions for the event scheduler.
//   - Event indices and the one-hot event bus width.
//   - FSM state type.
//   - Fixed-priority picker: UP, DOWN, RIGHT, LEFT, SPACE, FALL (highest first).
package event_scheduler_pkg;

    localparam int EVENT_LEN       = 6;
    localparam int EVENT_FALL      = 0;
    localparam int EVENT_KEY_UP    = 1;
    localparam int EVENT_KEY_DOWN  = 2;
    localparam int EVENT_KEY_LEFT  = 3;
    localparam int EVENT_KEY_RIGHT = 4;
    localparam int EVENT_KEY_SPACE = 5;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } sched_state_e;

    // Returns a one-hot vector holding the highest-priority set bit of req,
    // or all-zero when req is empty. RIGHT deliberately outranks LEFT even
    // though its index is higher.
    function automatic logic [EVENT_LEN-1:0] pick_highest(input logic [EVENT_LEN-1:0] req);
        logic [EVENT_LEN-1:0] sel;
        sel = '0;
        if (req[EVENT_KEY_UP])
            sel[EVENT_KEY_UP] = 1'b1;
        else if (req[EVENT_KEY_DOWN])
            sel[EVENT_KEY_DOWN] = 1'b1;
        else if (req[EVENT_KEY_RIGHT])
            sel[EVENT_KEY_RIGHT] = 1'b1;
        else if (req[EVENT_KEY_LEFT])
            sel[EVENT_KEY_LEFT] = 1'b1;
        else if (req[EVENT_KEY_SPACE])
            sel[EVENT_KEY_SPACE] = 1'b1;
        else if (req[EVENT_FALL])
            sel[EVENT_FALL] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/event_scheduler_gravity_timer.sv
// gravity_timer: free-running gravity period counter.
// Ports:
//   clk     - main clock
//   rst     - asynchronous active-high reset
//   level   - current game level (0..15), selects the period
//   pause   - holds the count and suppresses ticks
//   restart - reloads the count to 0 and suppresses any tick this cycle
//   tick    - one-cycle pulse at the terminal count
module gravity_timer
    import event_scheduler_pkg::*;
#(
    parameter int FALL_BASE = 3000,
    parameter int FALL_STEP = 180,
    parameter int FALL_MIN  = 300,
    parameter int PERIOD_W  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] level,
    input  logic       pause,
    input  logic       restart,
    output logic       tick
);

    localparam int CALC_W = PERIOD_W + 4;

    // Period for a level, floored at FALL_MIN. The product is formed four
    // bits wider than the counter so a large level never wraps the
    // subtraction into a bogus long period.
    function automatic logic [PERIOD_W-1:0] level_period(input logic [3:0] lvl);
        logic [CALC_W-1:0] dec;
        logic [CALC_W-1:0] base;
        logic [CALC_W-1:0] floor_v;
        dec     = CALC_W'(lvl) * CALC_W'(FALL_STEP);
        base    = CALC_W'(FALL_BASE);
        floor_v = CALC_W'(FALL_MIN);
        if ((dec >= base) || ((base - dec) < floor_v))
            return PERIOD_W'(FALL_MIN);
        else
            return PERIOD_W'(base - dec);
    endfunction

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cur_p;
    logic                at_end;

    // While the count sits at 0 (start of a period) the period follows the
    // level; once counting starts it is frozen in period_q, so a level
    // change only affects the next period.
    assign cur_p    = (cnt_q == '0) ? level_period(level) : period_q;
    assign period_d = cur_p;
    assign at_end   = (cnt_q == (cur_p - PERIOD_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (!pause) begin
            if (at_end) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/event_scheduler.sv
// event_scheduler: latches key pulses and gravity ticks as pending
// requests and presents them one at a time, by fixed priority, on a
// one-hot bus held until the consumer acknowledges it.
// Ports:
//   clk            - main clock
//   rst            - asynchronous active-high reset
//   key_pulse      - one-cycle key pulses, bit i = event index i+1
//   level          - current level, sets the gravity period
//   pause          - freezes gravity and withholds new grants
//   event_received - one-hot acknowledge from the consumer
//   event_out      - registered one-hot presented event, or zero
//   overrun        - sticky: a request hit an already-pending event
module event_scheduler
    import event_scheduler_pkg::*;
#(
    parameter int FALL_BASE = 3000,
    parameter int FALL_STEP = 180,
    parameter int FALL_MIN  = 300,
    parameter int PERIOD_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           key_pulse,
    input  logic [3:0]           level,
    input  logic                 pause,
    input  logic [EVENT_LEN-1:0] event_received,
    output logic [EVENT_LEN-1:0] event_out,
    output logic                 overrun
);

    sched_state_e         state_q, state_d;
    logic [EVENT_LEN-1:0] pending_q, pending_d;
    logic [EVENT_LEN-1:0] grant_q, grant_d;
    logic                 overrun_q, overrun_d;

    logic                 tick;
    logic                 restart;
    logic                 ack_hit;
    logic [EVENT_LEN-1:0] set_vec;
    logic [EVENT_LEN-1:0] clr_vec;
    logic [EVENT_LEN-1:0] kept;

    gravity_timer #(
        .FALL_BASE (FALL_BASE),
        .FALL_STEP (FALL_STEP),
        .FALL_MIN  (FALL_MIN),
        .PERIOD_W  (PERIOD_W)
    ) u_gravity (
        .clk     (clk),
        .rst     (rst),
        .level   (level),
        .pause   (pause),
        .restart (restart),
        .tick    (tick)
    );

    // Bit 0 is the gravity tick; key bit i maps to event index i+1.
    assign set_vec = {key_pulse, tick};

    // Only the acknowledge bit matching the live grant counts.
    assign ack_hit = (state_q == ST_GRANTED) && ((event_received & grant_q) != '0);
    assign clr_vec = ack_hit ? grant_q : '0;

    // Dropping a piece (DOWN/SPACE) starts a fresh gravity period.
    assign restart = ack_hit && (grant_q[EVENT_KEY_SPACE] || grant_q[EVENT_KEY_DOWN]);

    // A request for a bit being cleared this cycle is a fresh request, not
    // a duplicate; set still wins over clear.
    assign kept      = pending_q & ~clr_vec;
    assign pending_d = kept | set_vec;
    assign overrun_d = overrun_q | ((set_vec & kept) != '0);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((pending_q != '0) && !pause) begin
                    grant_d = pick_highest(pending_q);
                    state_d = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                // No preemption and pause does not withdraw: only the
                // matching acknowledge ends a grant.
                if (ack_hit) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            overrun_q <= overrun_d;
        end
    end

    assign event_out = grant_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_event_scheduler.sv
module tb_event_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] key_pulse = '0;
    logic [3:0] level = '0;
    logic       pause = 1'b0;
    logic [5:0] event_received = '0;
    logic [5:0] event_out;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    event_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .key_pulse      (key_pulse),
        .level          (level),
        .pause          (pause),
        .event_received (event_received),
        .event_out      (event_out),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Every observation happens at a falling edge; after the k-th call
    // following do_reset, exactly k rising edges have occurred.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic ack(input logic [5:0] v);
        event_received = v;
        step();
        event_received = '0;
    endtask

    // Cycles until event_out becomes non-zero; -1 if the budget expires.
    task automatic wait_grant(input int budget, output int cycles, output logic [5:0] seen);
        logic done;
        done   = 1'b0;
        cycles = 0;
        seen   = '0;
        while (!done && cycles < budget) begin
            step();
            cycles++;
            if (event_out != '0) begin
                seen = event_out;
                done = 1'b1;
            end
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL reset_event_out: got %b expected %b", event_out, 6'b0); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_tests++;
        if (dut.pending_q !== 6'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected %b", dut.pending_q, 6'b0); end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_gravity_level0();
        int c; logic [5:0] s;
        level = 4'd0;
        do_reset();
        wait_grant(3100, c, s);
        n_tests++;
        if (c !== 3001) begin n_fail++; $display("FAIL grav0_first_cycle: got %0d expected 3001", c); end
        n_tests++;
        if (s !== 6'b000001) begin n_fail++; $display("FAIL grav0_first_event: got %b expected 000001", s); end
        ack(6'b000001);
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL grav0_after_ack: got %b expected 000000", event_out); end
        wait_grant(3100, c, s);
        n_tests++;
        if (c !== 2999) begin n_fail++; $display("FAIL grav0_second_cycle: got %0d expected 2999", c); end
        n_tests++;
        if (s !== 6'b000001) begin n_fail++; $display("FAIL grav0_second_event: got %b expected 000001", s); end
        ack(6'b000001);
    endtask

    task automatic test_priority();
        level = 4'd0;
        do_reset();
        step(); step();
        key_pulse = 5'b00101;
        step();
        key_pulse = '0;
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL prio_latency: got %b expected 000000", event_out); end
        step();
        n_tests++;
        if (event_out !== 6'b000010) begin n_fail++; $display("FAIL prio_up_first: got %b expected 000010", event_out); end
        ack(6'b000010);
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL prio_idle_gap: got %b expected 000000", event_out); end
        step();
        n_tests++;
        if (event_out !== 6'b001000) begin n_fail++; $display("FAIL prio_left_second: got %b expected 001000", event_out); end
        ack(6'b001000);
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL prio_left_ack: got %b expected 000000", event_out); end
        n_tests++;
        if (dut.pending_q !== 6'b0) begin n_fail++; $display("FAIL prio_pending_empty: got %b expected 000000", dut.pending_q); end
    endtask

    task automatic test_no_preempt();
        level = 4'd0;
        do_reset();
        step();
        key_pulse = 5'b00100;
        step();
        key_pulse = '0;
        step();
        n_tests++;
        if (event_out !== 6'b001000) begin n_fail++; $display("FAIL nopre_left: got %b expected 001000", event_out); end
        key_pulse = 5'b01000;
        step();
        key_pulse = '0;
        n_tests++;
        if (event_out !== 6'b001000) begin n_fail++; $display("FAIL nopre_held: got %b expected 001000", event_out); end
        ack(6'b010000);
        n_tests++;
        if (event_out !== 6'b001000) begin n_fail++; $display("FAIL nopre_wrong_ack: got %b expected 001000", event_out); end
        ack(6'b001000);
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL nopre_gap: got %b expected 000000", event_out); end
        step();
        n_tests++;
        if (event_out !== 6'b010000) begin n_fail++; $display("FAIL nopre_right: got %b expected 010000", event_out); end
        ack(6'b010000);
    endtask

    task automatic test_overrun_space();
        level = 4'd0;
        do_reset();
        step();
        key_pulse = 5'b10000;
        step();
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b expected 0", overrun); end
        step();
        key_pulse = '0;
        n_tests++;
        if (event_out !== 6'b100000) begin n_fail++; $display("FAIL ovr_space_grant: got %b expected 100000", event_out); end
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        event_received = 6'b100000;
        key_pulse = 5'b10000;
        step();
        event_received = '0;
        key_pulse = '0;
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL ovr_ack_drop: got %b expected 000000", event_out); end
        step();
        n_tests++;
        if (event_out !== 6'b100000) begin n_fail++; $display("FAIL ovr_represent: got %b expected 100000", event_out); end
        ack(6'b100000);
        step(); step();
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL ovr_no_extra: got %b expected 000000", event_out); end
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        do_reset();
        step();
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_cleared: got %b expected 0", overrun); end
    endtask

    task automatic test_level15();
        int c; logic [5:0] s;
        level = 4'd15;
        do_reset();
        wait_grant(400, c, s);
        n_tests++;
        if (c !== 301) begin n_fail++; $display("FAIL lvl15_first: got %0d expected 301", c); end
        ack(6'b000001);
        wait_grant(400, c, s);
        n_tests++;
        if (c !== 299) begin n_fail++; $display("FAIL lvl15_second: got %0d expected 299", c); end
        n_tests++;
        if (s !== 6'b000001) begin n_fail++; $display("FAIL lvl15_event: got %b expected 000001", s); end
        ack(6'b000001);
    endtask

    task automatic test_level_change();
        int c; logic [5:0] s;
        level = 4'd14;
        do_reset();
        repeat (100) step();
        level = 4'd15;
        wait_grant(600, c, s);
        n_tests++;
        if (c !== 381) begin n_fail++; $display("FAIL lvlchg_current_480: got %0d expected 381", c); end
        ack(6'b000001);
        wait_grant(600, c, s);
        n_tests++;
        if (c !== 299) begin n_fail++; $display("FAIL lvlchg_next_300: got %0d expected 299", c); end
        ack(6'b000001);
    endtask

    task automatic test_pause();
        int c; int bad; logic [5:0] s;
        level = 4'd15;
        do_reset();
        repeat (100) step();
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 10) key_pulse = 5'b00001;
            if (i == 11) key_pulse = '0;
            step();
            if (event_out != '0) bad++;
        end
        pause = 1'b0;
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL pause_quiet: got %0d grant cycles expected 0", bad); end
        step();
        n_tests++;
        if (event_out !== 6'b000010) begin n_fail++; $display("FAIL pause_release_up: got %b expected 000010", event_out); end
        ack(6'b000010);
        wait_grant(400, c, s);
        n_tests++;
        if (c !== 199) begin n_fail++; $display("FAIL pause_resume_count: got %0d expected 199", c); end
        n_tests++;
        if (s !== 6'b000001) begin n_fail++; $display("FAIL pause_fall: got %b expected 000001", s); end
        ack(6'b000001);
    endtask

    task automatic test_restart_down();
        int c; logic [5:0] s;
        level = 4'd15;
        do_reset();
        repeat (100) step();
        key_pulse = 5'b00010;
        step();
        key_pulse = '0;
        step();
        n_tests++;
        if (event_out !== 6'b000100) begin n_fail++; $display("FAIL rst_down_grant: got %b expected 000100", event_out); end
        ack(6'b000100);
        wait_grant(400, c, s);
        n_tests++;
        if (c !== 301) begin n_fail++; $display("FAIL restart_period: got %0d expected 301", c); end
        ack(6'b000001);
    endtask

    task automatic test_async_reset();
        level = 4'd0;
        do_reset();
        step();
        key_pulse = 5'b00001;
        step();
        key_pulse = '0;
        step();
        n_tests++;
        if (event_out !== 6'b000010) begin n_fail++; $display("FAIL async_pre_grant: got %b expected 000010", event_out); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL async_drop: got %b expected 000000", event_out); end
        #1;
        rst = 1'b0;
        step();
        n_tests++;
        if (event_out !== 6'b0) begin n_fail++; $display("FAIL async_stays_idle: got %b expected 000000", event_out); end
        n_tests++;
        if (dut.pending_q !== 6'b0) begin n_fail++; $display("FAIL async_pending: got %b expected 000000", dut.pending_q); end
    endtask

    initial begin
        test_reset();
        test_gravity_level0();
        test_priority();
        test_no_preempt();
        test_overrun_space();
        test_level15();
        test_level_change();
        test_pause();
        test_restart_down();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
